// File: rtl/pooling_layer_v2_pkg.sv
//==============================================================================
// pooling_layer_v2_pkg - shared pooling mode codes and sizing helpers (rev 1.0)
//==============================================================================
`default_nettype none

package pooling_layer_v2_pkg;

  localparam logic POOL_MODE_MAX = 1'b0;
  localparam logic POOL_MODE_AVG = 1'b1;

  // Counter width helper; never returns less than one bit.
  function automatic int log2c(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pooling_reduce_unit.sv
//==============================================================================
// pooling_reduce_unit - registered max/average reduction of one F x F window (rev 1.0)
//==============================================================================
`default_nettype none

module pooling_reduce_unit
  import pooling_layer_v2_pkg::*;
#(
  parameter int I_WIDTH     = 8,
  parameter int FILTER_SIZE = 2,
  parameter int AVG_EN      = 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     i_valid,
  input  logic                                     i_mode,
  input  logic [I_WIDTH*FILTER_SIZE*FILTER_SIZE-1:0] i_window,
  output logic [I_WIDTH-1:0]                       o_pixel
);

  localparam int NPIX = FILTER_SIZE * FILTER_SIZE;
  localparam int LF   = $clog2(FILTER_SIZE);
  localparam int SW   = I_WIDTH + 2 * LF;

  logic [I_WIDTH-1:0] w_max;
  logic [I_WIDTH-1:0] w_avg;
  logic [I_WIDTH-1:0] w_result;

  always_comb begin
    w_max = '0;
    for (int i = 0; i < NPIX; i++) begin
      if (i_window[i*I_WIDTH +: I_WIDTH] > w_max) w_max = i_window[i*I_WIDTH +: I_WIDTH];
    end
  end

  generate
    if (AVG_EN != 0) begin : g_avg
      if (!is_pow2(FILTER_SIZE)) begin : g_bad_filter
        $error("pooling_reduce_unit: FILTER_SIZE must be a power of two when AVG_EN=1");
      end

      logic [SW-1:0] w_sum;

      always_comb begin
        w_sum = '0;
        for (int i = 0; i < NPIX; i++) begin
          w_sum = w_sum + SW'(i_window[i*I_WIDTH +: I_WIDTH]);
        end
      end

      // Divide by F*F as a truncating shift; the quotient always fits I_WIDTH.
      assign w_avg = I_WIDTH'(w_sum >> (2 * LF));
    end else begin : g_no_avg
      assign w_avg = '0;
    end
  endgenerate

  assign w_result = ((AVG_EN != 0) && (i_mode == POOL_MODE_AVG)) ? w_avg : w_max;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_pixel <= '0;
    end else if (i_valid) begin
      o_pixel <= w_result;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pooling_layer_v2.sv
//==============================================================================
// pooling_layer_v2 - streaming multi-channel 2-D max/average pooling layer (rev 1.0)
//==============================================================================
`default_nettype none

module pooling_layer_v2
  import pooling_layer_v2_pkg::*;
#(
  parameter int I_WIDTH     = 8,
  parameter int CHANNELS    = 1,
  parameter int FILTER_SIZE = 2,
  parameter int IMAGE_SIZE  = 8,
  parameter int STRIDE      = 2,
  parameter int AVG_EN      = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         mode,
  input  logic [I_WIDTH*CHANNELS-1:0]  input_data,
  output logic [I_WIDTH*CHANNELS-1:0]  output_data,
  output logic                         out_valid,
  output logic                         frame_done
);

  localparam int CW       = log2c(IMAGE_SIZE);
  localparam int PW       = log2c(STRIDE);
  localparam int OUT_SIZE = (IMAGE_SIZE - FILTER_SIZE) / STRIDE + 1;
  localparam int WBUS     = I_WIDTH * FILTER_SIZE * FILTER_SIZE;

  localparam logic [CW-1:0] LAST_POS  = CW'(IMAGE_SIZE - 1);
  localparam logic [CW-1:0] WIN_START = CW'(FILTER_SIZE - 1);
  localparam logic [CW-1:0] WIN_LAST  = CW'(FILTER_SIZE - 1 + (OUT_SIZE - 1) * STRIDE);
  localparam logic [PW-1:0] PH_LAST   = PW'(STRIDE - 1);

  logic [CW-1:0] r_col;
  logic [CW-1:0] r_row;
  logic [PW-1:0] r_col_ph;
  logic [PW-1:0] r_row_ph;
  logic          r_mode;

  logic w_first;
  logic w_mode_in;
  logic w_win_done;
  logic w_frame_last;
  logic w_row_end;

  assign w_first      = (r_col == '0) && (r_row == '0);
  assign w_mode_in    = (AVG_EN != 0) ? mode : POOL_MODE_MAX;
  assign w_row_end    = (r_col == LAST_POS);
  assign w_win_done   = (r_col >= WIN_START) && (r_row >= WIN_START) &&
                        (r_col_ph == '0) && (r_row_ph == '0);
  assign w_frame_last = w_win_done && (r_col == WIN_LAST) && (r_row == WIN_LAST);

  // Stride phases stay at 0 until the first full window, then count mod STRIDE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col    <= '0;
      r_row    <= '0;
      r_col_ph <= '0;
      r_row_ph <= '0;
      r_mode   <= POOL_MODE_MAX;
    end else if (in_valid) begin
      if (w_first) r_mode <= w_mode_in;
      if (w_row_end) begin
        r_col    <= '0;
        r_col_ph <= '0;
        if (r_row == LAST_POS) begin
          r_row    <= '0;
          r_row_ph <= '0;
        end else begin
          r_row <= r_row + 1'b1;
          if (r_row >= WIN_START) r_row_ph <= (r_row_ph == PH_LAST) ? '0 : r_row_ph + 1'b1;
        end
      end else begin
        r_col <= r_col + 1'b1;
        if (r_col >= WIN_START) r_col_ph <= (r_col_ph == PH_LAST) ? '0 : r_col_ph + 1'b1;
      end
    end
  end

  logic                        r_px_valid;
  logic                        r_px_done;
  logic                        r_px_last;
  logic                        r_px_mode;
  logic [CW-1:0]               r_px_col;
  logic [I_WIDTH*CHANNELS-1:0] r_px_data;
  logic                        r_s1_valid;
  logic                        r_s1_last;
  logic                        r_s1_mode;
  logic                        r_out_valid;
  logic                        r_frame_done;

  // Capture stage, window-update stage, then the registered reduction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_px_valid   <= 1'b0;
      r_px_done    <= 1'b0;
      r_px_last    <= 1'b0;
      r_px_mode    <= POOL_MODE_MAX;
      r_px_col     <= '0;
      r_px_data    <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_last    <= 1'b0;
      r_s1_mode    <= POOL_MODE_MAX;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_px_valid <= in_valid;
      if (in_valid) begin
        r_px_data <= input_data;
        r_px_col  <= r_col;
        r_px_done <= w_win_done;
        r_px_last <= w_frame_last;
        r_px_mode <= w_first ? w_mode_in : r_mode;
      end
      r_s1_valid <= r_px_valid && r_px_done;
      r_s1_last  <= r_px_valid && r_px_last;
      if (r_px_valid) r_s1_mode <= r_px_mode;
      r_out_valid  <= r_s1_valid;
      r_frame_done <= r_s1_valid && r_s1_last;
    end
  end

  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [I_WIDTH-1:0] w_pixel;
      logic [I_WIDTH-1:0] w_newcol [FILTER_SIZE];
      logic [I_WIDTH-1:0] r_win    [FILTER_SIZE][FILTER_SIZE];
      logic [WBUS-1:0]    w_win_bus;

      assign w_pixel                 = r_px_data[c*I_WIDTH +: I_WIDTH];
      assign w_newcol[FILTER_SIZE-1] = w_pixel;

      if (FILTER_SIZE > 1) begin : g_lb
        // Cascaded line buffers: r_lb[k] holds the row k+1 above the current one.
        logic [I_WIDTH-1:0] r_lb [FILTER_SIZE-1][IMAGE_SIZE];

        for (genvar k = 0; k < FILTER_SIZE - 1; k++) begin : g_tap
          assign w_newcol[FILTER_SIZE-2-k] = r_lb[k][r_px_col];
        end

        always_ff @(posedge clk) begin
          if (r_px_valid) begin
            r_lb[0][r_px_col] <= w_pixel;
            for (int k = 1; k < FILTER_SIZE - 1; k++) begin
              r_lb[k][r_px_col] <= r_lb[k-1][r_px_col];
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        if (r_px_valid) begin
          for (int r = 0; r < FILTER_SIZE; r++) begin
            for (int f = 0; f < FILTER_SIZE - 1; f++) begin
              r_win[r][f] <= r_win[r][f+1];
            end
            r_win[r][FILTER_SIZE-1] <= w_newcol[r];
          end
        end
      end

      for (genvar r = 0; r < FILTER_SIZE; r++) begin : g_row
        for (genvar f = 0; f < FILTER_SIZE; f++) begin : g_col
          assign w_win_bus[(r*FILTER_SIZE+f)*I_WIDTH +: I_WIDTH] = r_win[r][f];
        end
      end

      pooling_reduce_unit #(
        .I_WIDTH     (I_WIDTH),
        .FILTER_SIZE (FILTER_SIZE),
        .AVG_EN      (AVG_EN)
      ) u_reduce (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (r_s1_valid),
        .i_mode   (r_s1_mode),
        .i_window (w_win_bus),
        .o_pixel  (output_data[c*I_WIDTH +: I_WIDTH])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pooling_layer_v2.sv
//==============================================================================
// tb_pooling_layer_v2 - randomized self-checking bench with a frame-level pooling model (rev 1.0)
//==============================================================================
`default_nettype none

module tb_pooling_layer_v2;

  localparam int W  = 8;
  localparam int F  = 2;
  localparam int S  = 2;
  localparam int CH = 2;
  localparam int NA = 4;
  localparam int NB = 5;

  typedef struct {
    logic [15:0] data;
    logic        last;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          iv_a, mode_a, iv_b, mode_b;
  logic [W*CH-1:0] in_a, out_a;
  logic [W-1:0]  in_b, out_b;
  logic          ov_a, fd_a, ov_b, fd_b;

  int   cyc = 0;
  int   ntests = 0;
  int   nfail = 0;
  exp_t qa[$];
  exp_t qb[$];
  int   pix [CH][NB][NB];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pooling_layer_v2 #(
    .I_WIDTH(W), .CHANNELS(CH), .FILTER_SIZE(F), .IMAGE_SIZE(NA), .STRIDE(S), .AVG_EN(1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .mode(mode_a), .input_data(in_a),
    .output_data(out_a), .out_valid(ov_a), .frame_done(fd_a)
  );

  pooling_layer_v2 #(
    .I_WIDTH(W), .CHANNELS(1), .FILTER_SIZE(F), .IMAGE_SIZE(NB), .STRIDE(S), .AVG_EN(1)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .mode(mode_b), .input_data(in_b),
    .output_data(out_b), .out_valid(ov_b), .frame_done(fd_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: max or truncated mean over the window at output grid point (oy,ox).
  function automatic int pool(input int ch, input int oy, input int ox, input logic m);
    int mx = 0;
    int sum = 0;
    for (int dy = 0; dy < F; dy++) begin
      for (int dx = 0; dx < F; dx++) begin
        int v;
        v = pix[ch][oy*S+dy][ox*S+dx];
        sum += v;
        if (v > mx) mx = v;
      end
    end
    return m ? sum / (F * F) : mx;
  endfunction

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      iv_a = 1'b0; iv_b = 1'b0;
      in_a = 16'($urandom); in_b = 8'($urandom);
    end
  endtask

  task automatic send_frame(input int which, input logic m0, input int toggle_at, input bit gaps,
                            input bit ramp, input int npix, input bit drop_last);
    int   n;
    int   nout;
    logic mi;
    exp_t e;
    n    = (which == 0) ? NA : NB;
    nout = (n - F) / S + 1;
    for (int i = 0; i < n * n; i++) begin
      for (int ch = 0; ch < CH; ch++) begin
        pix[ch][i/n][i%n] = ramp ? ((ch == 0) ? i : 15 - i) : int'($urandom_range(0, 255));
      end
    end
    for (int i = 0; i < npix; i++) begin
      int r;
      int c;
      r = i / n;
      c = i % n;
      if (gaps && i > 0) begin
        @(negedge clk);
        iv_a = 1'b0; iv_b = 1'b0;
        in_a = 16'($urandom); in_b = 8'($urandom);
      end
      @(negedge clk);
      mi = (toggle_at >= 0 && i >= toggle_at) ? ~m0 : m0;
      if (which == 0) begin
        iv_a = 1'b1; mode_a = mi;
        in_a = {8'(pix[1][r][c]), 8'(pix[0][r][c])};
      end else begin
        iv_b = 1'b1; mode_b = mi;
        in_b = 8'(pix[0][r][c]);
      end
      for (int oy = 0; oy < nout; oy++) begin
        for (int ox = 0; ox < nout; ox++) begin
          if (oy * S + F - 1 == r && ox * S + F - 1 == c && !(drop_last && i == npix - 1)) begin
            e.data = (which == 0) ? {8'(pool(1, oy, ox, m0)), 8'(pool(0, oy, ox, m0))}
                                  : {8'h00, 8'(pool(0, oy, ox, m0))};
            e.last = (oy == nout - 1) && (ox == nout - 1);
            e.cyc  = cyc + 3;
            if (which == 0) qa.push_back(e);
            else            qb.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    iv_a = 1'b1; in_a = 16'($urandom); mode_a = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", 64'(ov_a), 64'(0));
    check("rst_mid_frame_done", 64'(fd_a), 64'(0));
    check("rst_mid_output_data", 64'(out_a), 64'(0));
    rst_n = 1'b1;
    iv_a = 1'b0;
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    while (qa.size() > 0 && qa[0].cyc < cyc) begin
      check("a_output_missing_at_cycle", 64'(cyc), 64'(qa[0].cyc));
      void'(qa.pop_front());
    end
    if (ov_a) begin
      if (qa.size() == 0) begin
        check("a_unexpected_out_valid", 64'(ov_a), 64'(0));
      end else begin
        e = qa.pop_front();
        check("a_output_data", 64'(out_a), 64'(e.data));
        check("a_frame_done", 64'(fd_a), 64'(e.last));
        check("a_latency_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else if (fd_a) begin
      check("a_frame_done_without_valid", 64'(fd_a), 64'(0));
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    while (qb.size() > 0 && qb[0].cyc < cyc) begin
      check("b_output_missing_at_cycle", 64'(cyc), 64'(qb[0].cyc));
      void'(qb.pop_front());
    end
    if (ov_b) begin
      if (qb.size() == 0) begin
        check("b_unexpected_out_valid", 64'(ov_b), 64'(0));
      end else begin
        e = qb.pop_front();
        check("b_output_data", 64'(out_b), 64'(e.data));
        check("b_frame_done", 64'(fd_b), 64'(e.last));
        check("b_latency_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else if (fd_b) begin
      check("b_frame_done_without_valid", 64'(fd_b), 64'(0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    iv_a = 1'b1; iv_b = 1'b1; mode_a = 1'b1; mode_b = 1'b1;
    in_a = 16'($urandom); in_b = 8'($urandom);
    repeat (3) @(negedge clk);
    check("reset_out_valid_a", 64'(ov_a), 64'(0));
    check("reset_frame_done_a", 64'(fd_a), 64'(0));
    check("reset_output_data_a", 64'(out_a), 64'(0));
    check("reset_out_valid_b", 64'(ov_b), 64'(0));
    check("reset_output_data_b", 64'(out_b), 64'(0));
    rst_n = 1'b1;
    iv_a = 1'b0; iv_b = 1'b0;

    // Ramp frames back to back: max, average, then max with idle cycles between pixels.
    send_frame(0, 1'b0, -1, 1'b0, 1'b1, NA * NA, 1'b0);
    send_frame(0, 1'b1, -1, 1'b0, 1'b1, NA * NA, 1'b0);
    send_frame(0, 1'b0, -1, 1'b1, 1'b1, NA * NA, 1'b0);
    // Random frames: mid-frame mode toggle stays max, next frame picks up average.
    send_frame(0, 1'b0, 6, 1'b0, 1'b0, NA * NA, 1'b0);
    send_frame(0, 1'b1, -1, 1'b0, 1'b0, NA * NA, 1'b0);
    send_frame(0, 1'b1, -1, 1'b1, 1'b0, NA * NA, 1'b0);
    send_frame(0, 1'b0, -1, 1'b0, 1'b0, NA * NA, 1'b0);
    idle(4);

    // Reset after pixel 9, then a full frame.
    send_frame(0, 1'b0, -1, 1'b0, 1'b1, 10, 1'b0);
    pulse_reset();
    send_frame(0, 1'b0, -1, 1'b0, 1'b0, NA * NA, 1'b0);
    idle(4);

    // Reset right behind a window-completing pixel: its result must never appear.
    send_frame(0, 1'b1, -1, 1'b0, 1'b0, 6, 1'b1);
    pulse_reset();
    send_frame(0, 1'b1, -1, 1'b0, 1'b0, NA * NA, 1'b0);
    idle(4);

    // N=5: trailing row and column produce no output.
    send_frame(1, 1'b1, -1, 1'b0, 1'b0, NB * NB, 1'b0);
    send_frame(1, 1'b0, -1, 1'b1, 1'b0, NB * NB, 1'b0);
    idle(6);

    for (int k = 0; k < 20 && (qa.size() != 0 || qb.size() != 0); k++) @(negedge clk);
    check("drain_pending_a", 64'(qa.size()), 64'(0));
    check("drain_pending_b", 64'(qb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pooling_layer_v2.md
# pooling_layer_v2

Streaming, multi-channel 2-D pooling layer with runtime-selectable max or average mode, synchronous reset and explicit input/output valid qualification. Sits between convolution layers in the CNN pipeline. It consumes one pixel per channel per accepted cycle in raster order and emits one pooled pixel per channel per completed window. It replaces the fixed max-only pooling stage, which had no reset and no mode selection.

## Interface
- I_WIDTH, 8: unsigned pixel width per channel
- CHANNELS, 1: number of channels processed in parallel
- FILTER_SIZE, 2: pooling window side F (F×F window)
- IMAGE_SIZE, 8: input image side N (square image)
- STRIDE, 2: window step S, both axes, ≥1
- AVG_EN, 1: 1 builds the average path; requires F to be a power of two (elaboration error otherwise)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- in_valid  in  1  input_data valid this cycle; pixel accepted on rising clk when high
- mode  in  1  0 = max, 1 = average; ignored (treated as 0) when AVG_EN=0
- input_data  in  I_WIDTH*CHANNELS  channel c at [I_WIDTH*c +: I_WIDTH]
- output_data  out  I_WIDTH*CHANNELS  pooled pixel per channel, same packing
- out_valid  out  1  output_data valid, single-cycle pulse per window
- frame_done  out  1  pulses with the last out_valid of a frame

## Operation
- Column counter col and row counter row (each LOG2(N) bits) advance only on accepted pixels; col wraps N-1→0 and increments row; row wraps N-1→0 at end of frame.
- Per channel, F-1 line buffers of N entries, plus an F×F window register shifted on each accepted pixel.
- Window complete when row ≥ F-1, col ≥ F-1, (row-(F-1)) mod S = 0 and (col-(F-1)) mod S = 0. Track mod-S phases with separate stride counters, not dividers.
- Output grid is OUT_SIZE = (N-F)/S + 1 per side; trailing columns/rows not covering a full stride step produce no output.
- Max mode: unsigned maximum of the F² values.
- Average mode: sum in I_WIDTH + 2·LOG2(F) bits, then right shift by 2·LOG2(F) (truncation, no rounding).
- mode is sampled on the accepted pixel at (row,col) = (0,0) and held for the whole frame. Mid-frame changes have no effect until the next frame.
- in_valid low: counters, buffers and window hold; the pipeline still drains.

## Timing
- Latency: pixel completing a window accepted at edge E → out_valid high in the cycle after edge E+2 (stage 1 window update, stage 2 reduce and register).
- Throughput: one pixel/cycle sustained; no backpressure, so downstream must accept every out_valid.
- Reset (rst_n low at an edge): col, row, stride phases = 0; pipeline valids cleared; out_valid = 0, frame_done = 0, output_data = 0, latched mode = max. Line buffer RAM is not cleared; stale content is never used because a window needs F-1 freshly written rows.
- Reset mid-frame: in-flight results are discarded; the next accepted pixel is treated as (0,0).
- Frame boundary: the first pixel of the next frame may arrive in the cycle right after the last pixel. frame_done and the final out_valid are unaffected by new-frame input.
- in_valid high during reset: ignored.

## Structure
- Use the shared definitions include for the LOG2 macro. Add POOL_MODE_MAX = 1'b0 and POOL_MODE_AVG = 1'b1 there.
- Sub-module pooling_reduce_unit (per channel): takes the F² window bus and mode, outputs the registered reduced pixel; generated CHANNELS times.
- Counters and line-buffer addressing are shared across channels in the top level.

## Test plan
- N=4, F=2, S=2, CHANNELS=2, I_WIDTH=8, max mode, ch0 pixels 0..15 raster, ch1 = 15-pixel: ch0 outputs 5, 7, 13, 15; ch1 outputs 15, 13, 7, 5. Four out_valid pulses, each 2 cycles after the pixels at (1,1), (1,3), (3,1), (3,3); frame_done with the 4th.
- Same stream, average mode: ch0 outputs 2, 4, 10, 12 (truncated 10/4, 18/4, 42/4, 50/4).
- Same stream with in_valid deasserted every other cycle: identical values and order, each pulse 2 cycles after its completing pixel.
- N=5, F=2, S=2: 4 outputs per frame; row 4 and column 4 produce none.
- Toggle mode to avg at pixel 6 of a max frame: whole frame stays max; the next frame is avg.
- Assert rst_n low after pixel 9, then send a full 16-pixel frame: no stale out_valid, and exactly 4 correct outputs.
